uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter among NUM_REQ byte sources.
- Accepts one byte per grant over a valid/ready handshake.
- Launches it on the transmitter with a one-cycle start strobe and waits for the transmitter's done pulse.
- Optionally inserts an inter-byte idle gap.
- A watchdog recovers if done never arrives.
- Sits between the protocol/command blocks and the shared UART TX, alongside uart_receiver in the serial subsystem.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the serial subsystem (UART TX arbitration, RX dispatch).
package uart_pkg;

  localparam int unsigned UartDataW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2,
    StGap  = 2'd3
  } tx_arb_state_e;

  // Width of an index into n requesters; never zero so single-bit ports stay legal.
  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter import uart_pkg::*; #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = rr_idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              any_valid_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    // Modulo keeps the search inside 0..NumReq-1 for non-power-of-2 counts.
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = IdxW'((32'(ptr_i) + off) % NumReq);
      if (!any_valid_o && req_i[idx]) begin
        any_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among NumReq sources,
// with an optional inter-byte idle gap and a watchdog on the transmitter's done pulse.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned DataW         = UartDataW,
  parameter int unsigned GapCycles     = 0,
  parameter int unsigned TimeoutCycles = 4096,
  localparam int unsigned IdxW         = rr_idx_w(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*DataW-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic                    tx_en_o,
  output logic [DataW-1:0]        tx_data_o,
  input  logic                    tx_done_i,
  output logic [IdxW-1:0]         grant_id_o,
  output logic                    busy_o,
  output logic                    err_timeout_o
);

  localparam int unsigned TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned GapW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;

  tx_arb_state_e     state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   grant_id_q, grant_id_d;
  logic [DataW-1:0]  tx_data_q, tx_data_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              err_q, err_d;
  logic [NumReq-1:0] win_gnt;
  logic [IdxW-1:0]   win_idx;
  logic              any_valid;
  logic              tmo_hit;

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr_arbiter (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_o       (win_gnt),
    .gnt_idx_o   (win_idx),
    .any_valid_o (any_valid)
  );

  assign tmo_inc = (tmo_cnt_q == {TmoW{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + TmoW'(1);
  assign tmo_hit = (TimeoutCycles > 0) && (tmo_inc == TmoW'(TimeoutCycles));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          tx_data_d  = req_data_i[win_idx*DataW +: DataW];
          grant_id_d = win_idx;
          ptr_d      = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
          state_d    = StSend;
        end
      end
      StSend: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        // A done pulse in the same cycle as the watchdog expiring takes priority.
        if (tx_done_i) begin
          if (GapCycles > 0) begin
            gap_cnt_d = GapW'(GapCycles);
            state_d   = StGap;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q <= GapW'(1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
    end
  end

  // Grant is offered only while idle and never during reset.
  assign req_ready_o   = ((state_q == StIdle) && !rst_i) ? win_gnt : '0;
  assign tx_en_o       = (state_q == StSend);
  assign busy_o        = (state_q != StIdle);
  assign tx_data_o     = tx_data_q;
  assign grant_id_o    = grant_id_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: a 4-requester instance with a 100-cycle watchdog and a 3-requester
// instance with a 3-cycle inter-byte gap and the watchdog disabled.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a_valid, a_ready;
  logic [31:0] a_data;
  logic        a_en, a_done, a_busy, a_err;
  logic [7:0]  a_txd;
  logic [1:0]  a_gid;

  logic [2:0]  b_valid, b_ready;
  logic [23:0] b_data;
  logic        b_en, b_done, b_busy, b_err;
  logic [7:0]  b_txd;
  logic [1:0]  b_gid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  uart_tx_arbiter #(
    .NumReq        (4),
    .DataW         (8),
    .GapCycles     (0),
    .TimeoutCycles (100)
  ) u_dut_a (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (a_valid),
    .req_data_i    (a_data),
    .req_ready_o   (a_ready),
    .tx_en_o       (a_en),
    .tx_data_o     (a_txd),
    .tx_done_i     (a_done),
    .grant_id_o    (a_gid),
    .busy_o        (a_busy),
    .err_timeout_o (a_err)
  );

  uart_tx_arbiter #(
    .NumReq        (3),
    .DataW         (8),
    .GapCycles     (3),
    .TimeoutCycles (0)
  ) u_dut_b (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (b_valid),
    .req_data_i    (b_data),
    .req_ready_o   (b_ready),
    .tx_en_o       (b_en),
    .tx_data_o     (b_txd),
    .tx_done_i     (b_done),
    .grant_id_o    (b_gid),
    .busy_o        (b_busy),
    .err_timeout_o (b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One full transfer on instance A: grant in the current idle cycle, done dly cycles after tx_en.
  task automatic xfer_a(input string tag, input logic [3:0] vld, input logic [3:0] exp_rdy,
                        input logic [1:0] exp_gid, input logic [7:0] exp_byte,
                        input int unsigned dly);
    int unsigned extra_en;
    a_valid = vld;
    #1;
    check({tag, "_ready"}, a_ready, exp_rdy);
    step();
    check({tag, "_tx_en"}, a_en, 1);
    check({tag, "_gid"}, a_gid, exp_gid);
    check({tag, "_txd"}, a_txd, exp_byte);
    check({tag, "_ready_send"}, a_ready, 0);
    extra_en = 0;
    for (int i = 1; i < dly; i++) begin
      step();
      extra_en += a_en;
    end
    step();
    check({tag, "_busy_wait"}, a_busy, 1);
    a_done = 1'b1;
    step();
    a_done = 1'b0;
    check({tag, "_extra_en"}, extra_en, 0);
    check({tag, "_busy_after"}, a_busy, 0);
  endtask

  // Instance B from its tx_en cycle: done 2 cycles later, 3 gap cycles, then the next grant.
  task automatic gap_b(input string tag, input logic [2:0] exp_rdy, input logic [1:0] exp_gid,
                       input logic [7:0] exp_byte);
    int unsigned early_rdy;
    step();
    step();
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    check({tag, "_busy_gap"}, b_busy, 1);
    early_rdy = (b_ready != 0) ? 1 : 0;
    step();
    early_rdy += (b_ready != 0) ? 1 : 0;
    step();
    early_rdy += (b_ready != 0) ? 1 : 0;
    check({tag, "_early_ready"}, early_rdy, 0);
    step();
    check({tag, "_ready"}, b_ready, exp_rdy);
    check({tag, "_busy_idle"}, b_busy, 0);
    step();
    check({tag, "_tx_en"}, b_en, 1);
    check({tag, "_gid"}, b_gid, exp_gid);
    check({tag, "_txd"}, b_txd, exp_byte);
  endtask

  initial begin
    int unsigned seen;
    rst     = 1'b1;
    a_valid = 4'hF;
    b_valid = 3'h7;
    a_done  = 1'b0;
    b_done  = 1'b0;
    a_data  = 32'h0000_A500;
    b_data  = 24'hC2_B1_A0;
    step();
    step();
    check("rst_ready", a_ready, 0);
    check("rst_tx_en", a_en, 0);
    check("rst_txd", a_txd, 0);
    check("rst_gid", a_gid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_err", a_err, 0);
    check("rst_b_ready", b_ready, 0);
    rst     = 1'b0;
    a_valid = 4'h0;
    b_valid = 3'h0;
    step();

    // Single requester, long transmit.
    xfer_a("t1", 4'b0010, 4'b0010, 2'd1, 8'hA5, 20);
    a_valid = 4'h0;

    // Fair rotation with every requester permanently valid.
    rst = 1'b1;
    step();
    rst    = 1'b0;
    a_data = 32'h1312_1110;
    for (int g = 0; g < 6; g++) begin
      xfer_a("t2_rr", 4'hF, 4'(1 << (g % 4)), 2'(g % 4), 8'(8'h10 + g % 4), 5);
    end

    // Pointer after 2 favours 3 over 0.
    xfer_a("t3_g2", 4'b0100, 4'b0100, 2'd2, 8'h12, 3);
    xfer_a("t3_g3", 4'b1001, 4'b1000, 2'd3, 8'h13, 3);
    xfer_a("t3_g0", 4'b1001, 4'b0001, 2'd0, 8'h10, 3);

    // Watchdog abort after 100 WAIT cycles, then the next requester is served.
    a_valid = 4'b0010;
    #1;
    check("t4_ready", a_ready, 4'b0010);
    step();
    check("t4_tx_en", a_en, 1);
    a_valid = 4'b0100;
    seen = 0;
    for (int i = 1; i < 100; i++) begin
      step();
      seen += a_err;
    end
    step();
    check("t4_err_early", seen, 0);
    check("t4_err_last_wait", a_err, 0);
    check("t4_busy_last_wait", a_busy, 1);
    step();
    check("t4_err_pulse", a_err, 1);
    check("t4_busy_abort", a_busy, 0);
    check("t4_ready_next", a_ready, 4'b0100);
    step();
    check("t4_err_clear", a_err, 0);
    check("t4_tx_en_next", a_en, 1);
    check("t4_gid_next", a_gid, 2);
    a_valid = 4'h0;
    // Done exactly on the 100th WAIT cycle beats the watchdog.
    for (int i = 1; i < 100; i++) step();
    step();
    a_done = 1'b1;
    step();
    a_done = 1'b0;
    check("t4_done_wins_err", a_err, 0);
    check("t4_done_wins_busy", a_busy, 0);

    // Reset during WAIT; a stale done afterwards is ignored.
    a_valid = 4'b0010;
    #1;
    check("t6_ready", a_ready, 4'b0010);
    step();
    a_valid = 4'h0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_tx_en", a_en, 0);
    check("t6_txd", a_txd, 0);
    check("t6_gid", a_gid, 0);
    check("t6_busy", a_busy, 0);
    check("t6_err", a_err, 0);
    check("t6_ready0", a_ready, 0);
    step();
    a_done = 1'b1;
    step();
    a_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen += a_en + a_busy + a_err;
    end
    check("t6_stale_done", seen, 0);
    a_valid = 4'hF;
    #1;
    check("t6_ptr_zero", a_ready, 4'b0001);
    step();
    check("t6_tx_en_new", a_en, 1);
    check("t6_gid_new", a_gid, 0);
    a_valid = 4'h0;

    // Three requesters: wrap 2 -> 0, and a 3-cycle gap between bytes.
    b_valid = 3'b100;
    #1;
    check("b_ready_first", b_ready, 3'b100);
    step();
    check("b_tx_en_first", b_en, 1);
    check("b_gid_first", b_gid, 2);
    check("b_txd_first", b_txd, 8'hC2);
    b_valid = 3'b011;
    gap_b("b_wrap", 3'b001, 2'd0, 8'hA0);
    gap_b("b_gap", 3'b010, 2'd1, 8'hB1);
    check("b_err_never", b_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
